// File: rtl/tc_pkg.sv
// Shared types and widths for the systolic array output path.
package tc_pkg;
   localparam int DEFAULT_ARRAY_WIDTH = 16;
   localparam int PSUM_W              = 32;
   localparam int COLSZ_W             = 16;

   typedef logic signed [PSUM_W-1:0] psum_t;
   typedef psum_t psum_row_t [DEFAULT_ARRAY_WIDTH];
endpackage

// File: rtl/systolic_output_deskew_if.sv
// Column stream in, aligned row stream out. Row handshake: a row transfers on
// every clk edge where row_valid_out and row_ready_in are both 1; the head row is stable until then.
interface systolic_output_deskew_if #(
   parameter int ARRAY_WIDTH = tc_pkg::DEFAULT_ARRAY_WIDTH,
   parameter int FIFO_DEPTH  = 4
);
   import tc_pkg::*;

   psum_t                        col_data_in [ARRAY_WIDTH];
   logic [ARRAY_WIDTH-1:0]       col_valid_in;
   logic [COLSZ_W-1:0]           ub_rd_col_size_in;
   logic                         ub_rd_col_size_valid_in;
   psum_t                        row_data_out [ARRAY_WIDTH];
   logic [ARRAY_WIDTH-1:0]       row_mask_out;
   logic                         row_valid_out;
   logic                         row_ready_in;
   logic [$clog2(FIFO_DEPTH):0]  fifo_count_out;
   logic                         overflow_err;
   logic                         skew_err;
   logic                         err_clear;

   modport slave (
      input  col_data_in, col_valid_in, ub_rd_col_size_in, ub_rd_col_size_valid_in,
      input  row_ready_in, err_clear,
      output row_data_out, row_mask_out, row_valid_out, fifo_count_out,
      output overflow_err, skew_err
   );

   modport master (
      output col_data_in, col_valid_in, ub_rd_col_size_in, ub_rd_col_size_valid_in,
      output row_ready_in, err_clear,
      input  row_data_out, row_mask_out, row_valid_out, fifo_count_out,
      input  overflow_err, skew_err
   );
endinterface

// File: rtl/deskew_delay.sv
// Fixed-length delay line for one column's psum and valid; DEPTH=0 is a pass-through.
module deskew_delay
   import tc_pkg::*;
#(
   parameter int DEPTH = 0
) (
   input  logic  clk,
   input  logic  rst,
   input  psum_t i_data,
   input  logic  i_valid,
   output psum_t o_data,
   output logic  o_valid
);
   generate
      if (DEPTH == 0) begin : g_wire
         logic w_unused;
         assign w_unused = clk ^ rst;
         assign o_data   = i_data;
         assign o_valid  = i_valid;
      end else begin : g_pipe
         psum_t            r_data [DEPTH];
         logic [DEPTH-1:0] r_valid;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
               r_valid <= '0;
            end else begin
               r_data[0]  <= i_data;
               r_valid[0] <= i_valid;
               for (int i = 1; i < DEPTH; i++) begin
                  r_data[i]  <= r_data[i-1];
                  r_valid[i] <= r_valid[i-1];
               end
            end
         end

         assign o_data  = r_data[DEPTH-1];
         assign o_valid = r_valid[DEPTH-1];
      end
   endgenerate
endmodule

// File: rtl/systolic_output_deskew.sv
// Re-aligns the skewed bottom-row psum columns into whole rows, masks inactive
// columns and buffers rows in a first-word-fall-through FIFO. Never back-pressures.
module systolic_output_deskew
   import tc_pkg::*;
#(
   parameter int ARRAY_WIDTH = DEFAULT_ARRAY_WIDTH,
   parameter int FIFO_DEPTH  = 4
) (
   input logic                   clk,
   input logic                   rst,
   systolic_output_deskew_if.slave bus
);
   localparam int N  = ARRAY_WIDTH;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   psum_t          w_al_data [N];
   logic [N-1:0]   w_al_valid;
   psum_t          w_row [N];
   logic [N-1:0]   w_mask_load;

   logic [N-1:0]   r_mask;
   psum_t          r_mem [FIFO_DEPTH][N];
   logic [N-1:0]   r_mask_mem [FIFO_DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic           r_ovf;
   logic           r_skew;

   logic w_push, w_pop, w_full, w_empty, w_write, w_drop, w_skew;

   // Column j waits N-1-j cycles so every column lines up with column N-1.
   genvar j;
   generate
      for (j = 0; j < N; j++) begin : g_col
         deskew_delay #(.DEPTH(N - 1 - j)) u_dly (
            .clk     (clk),
            .rst     (rst),
            .i_data  (bus.col_data_in[j]),
            .i_valid (bus.col_valid_in[j]),
            .o_data  (w_al_data[j]),
            .o_valid (w_al_valid[j])
         );
         assign w_row[j]            = r_mask[j] ? w_al_data[j] : '0;
         assign bus.row_data_out[j] = w_empty ? '0 : r_mem[r_rd_ptr][j];
      end
   endgenerate

   always_comb begin
      w_mask_load = '0;
      for (int c = 0; c < N; c++) w_mask_load[c] = (c < int'(bus.ub_rd_col_size_in));
   end

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_push  = w_al_valid[0];
   assign w_pop   = !w_empty && bus.row_ready_in;
   // A simultaneous pop frees the slot a full-FIFO push needs.
   assign w_write = w_push && (!w_full || w_pop);
   assign w_drop  = w_push && w_full && !w_pop;
   assign w_skew  = |(r_mask & (w_al_valid ^ {N{w_al_valid[0]}}));

   always_ff @(posedge clk) begin
      if (w_write) begin
         for (int c = 0; c < N; c++) r_mem[r_wr_ptr][c] <= w_row[c];
         r_mask_mem[r_wr_ptr] <= r_mask;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mask   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_skew   <= 1'b0;
      end else begin
         if (bus.ub_rd_col_size_valid_in) r_mask <= w_mask_load;
         if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_drop)             r_ovf <= 1'b1;
         else if (bus.err_clear) r_ovf <= 1'b0;
         if (w_skew)             r_skew <= 1'b1;
         else if (bus.err_clear) r_skew <= 1'b0;
      end
   end

   assign bus.row_valid_out  = !w_empty;
   assign bus.row_mask_out   = w_empty ? '0 : r_mask_mem[r_rd_ptr];
   assign bus.fifo_count_out = r_count;
   assign bus.overflow_err   = r_ovf;
   assign bus.skew_err       = r_skew;
endmodule

// File: tb/tb_systolic_output_deskew.sv
// Directed bench for systolic_output_deskew with a cycle-level reference model.
module tb_systolic_output_deskew;
   import tc_pkg::*;

   localparam int N   = 4;
   localparam int D   = 4;
   localparam int QW  = N * 32 + N;
   localparam int HIS = 2048;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   systolic_output_deskew_if #(.ARRAY_WIDTH(N), .FIFO_DEPTH(D)) bus ();

   systolic_output_deskew #(.ARRAY_WIDTH(N), .FIFO_DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: row pushed at edge t takes column j's sample from edge t-(N-1-j).
   bit              hv [HIS][N];
   int              hd [HIS][N];
   int              cyc        = 0;
   int              valid_from = 0;
   logic [QW-1:0]   exp_q [$];
   logic            m_ovf  = 1'b0;
   logic            m_skew = 1'b0;
   logic [N-1:0]    m_mask = '0;

   always @(posedge rst) begin
      exp_q.delete();
      m_ovf      = 1'b0;
      m_skew     = 1'b0;
      m_mask     = '0;
      valid_from = cyc;
   end

   always @(posedge clk) begin
      bit            av [N];
      int            ad [N];
      int            src;
      bit            sk, pop, full;
      logic [QW-1:0] ent;
      if (cyc >= HIS - 1) begin
         $display("FAIL model_history: cycle %0d beyond %0d", cyc, HIS - 1);
         $fatal(1);
      end
      if (rst) begin
         exp_q.delete();
         m_ovf  = 1'b0;
         m_skew = 1'b0;
         m_mask = '0;
         cyc++;
         valid_from = cyc;
      end else begin
         for (int j = 0; j < N; j++) begin
            hv[cyc][j] = bus.col_valid_in[j];
            hd[cyc][j] = bus.col_data_in[j];
         end
         for (int j = 0; j < N; j++) begin
            src = cyc - (N - 1 - j);
            av[j] = (src >= valid_from) ? hv[src][j] : 1'b0;
            ad[j] = (src >= valid_from) ? hd[src][j] : 0;
         end
         sk = 1'b0;
         for (int j = 0; j < N; j++) if (m_mask[j] && av[j] != av[0]) sk = 1'b1;
         pop  = (exp_q.size() != 0) && bus.row_ready_in;
         full = (exp_q.size() == D);
         if (bus.err_clear) begin
            m_ovf  = 1'b0;
            m_skew = 1'b0;
         end
         if (sk) m_skew = 1'b1;
         if (pop) void'(exp_q.pop_front());
         if (av[0]) begin
            if (full && !pop) m_ovf = 1'b1;
            else begin
               ent = '0;
               ent[N*32 +: N] = m_mask;
               for (int j = 0; j < N; j++) ent[j*32 +: 32] = m_mask[j] ? ad[j] : 0;
               exp_q.push_back(ent);
            end
         end
         if (bus.ub_rd_col_size_valid_in)
            m_mask = (int'(bus.ub_rd_col_size_in) >= N) ? {N{1'b1}}
                   : N'((1 << bus.ub_rd_col_size_in) - 1);
         cyc++;
      end
   end

   always @(negedge clk) begin
      logic [QW-1:0] head;
      chk("row_valid", bus.row_valid_out, exp_q.size() != 0);
      chk("fifo_count", bus.fifo_count_out, exp_q.size());
      chk("overflow_err", bus.overflow_err, m_ovf);
      chk("skew_err", bus.skew_err, m_skew);
      if (exp_q.size() != 0) begin
         head = exp_q[0];
         chk("row_mask", bus.row_mask_out, head[N*32 +: N]);
         for (int j = 0; j < N; j++)
            chk($sformatf("row_data[%0d]", j), bus.row_data_out[j], $signed(head[j*32 +: 32]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_size(input int s);
      bus.ub_rd_col_size_in       = 16'(s);
      bus.ub_rd_col_size_valid_in = 1'b1;
      step();
      bus.ub_rd_col_size_valid_in = 1'b0;
   endtask

   task automatic pulse_clear();
      bus.err_clear = 1'b1;
      step();
      bus.err_clear = 1'b0;
   endtask

   // Row r of column j is valid at cycle r+j (+off2 for column 2), value base+10*r+j.
   task automatic stream(input int nrows, input int base, input int off2, input int pop_at,
                         input int rst_at, output int first_vis);
      int len, r, off;
      len = nrows + N + off2;
      first_vis = -1;
      for (int c = 0; c < len; c++) begin
         if (c == rst_at) begin
            rst = 1'b1;
            #1;
            chk("rst_row_valid", bus.row_valid_out, 0);
            chk("rst_fifo_count", bus.fifo_count_out, 0);
            step();
            rst = 1'b0;
         end
         for (int j = 0; j < N; j++) begin
            off = (j == 2) ? off2 : 0;
            r   = c - j - off;
            bus.col_valid_in[j] = (r >= 0 && r < nrows);
            bus.col_data_in[j]  = (r >= 0 && r < nrows) ? base + 10 * r + j : 0;
         end
         bus.row_ready_in = (c == pop_at);
         step();
         if (first_vis < 0 && bus.row_valid_out) first_vis = c;
      end
      bus.col_valid_in = '0;
      for (int j = 0; j < N; j++) bus.col_data_in[j] = 0;
      bus.row_ready_in = 1'b0;
   endtask

   task automatic pop_row(input string name, input int d0, input int d1, input int d2,
                          input int d3, input logic [N-1:0] m);
      int exp_d [N];
      exp_d = '{d0, d1, d2, d3};
      chk({name, "_valid"}, bus.row_valid_out, 1);
      chk({name, "_mask"}, bus.row_mask_out, m);
      for (int j = 0; j < N; j++)
         chk($sformatf("%s_d%0d", name, j), bus.row_data_out[j], exp_d[j]);
      bus.row_ready_in = 1'b1;
      step();
      bus.row_ready_in = 1'b0;
   endtask

   initial begin
      int fv;
      rst = 1'b1;
      bus.col_valid_in            = '0;
      for (int j = 0; j < N; j++) bus.col_data_in[j] = 0;
      bus.ub_rd_col_size_in       = '0;
      bus.ub_rd_col_size_valid_in = 1'b0;
      bus.row_ready_in            = 1'b0;
      bus.err_clear               = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("reset_valid", bus.row_valid_out, 0);
      chk("reset_count", bus.fifo_count_out, 0);
      chk("reset_mask", bus.row_mask_out, 0);
      chk("reset_data0", bus.row_data_out[0], 0);
      chk("reset_ovf", bus.overflow_err, 0);
      chk("reset_skew", bus.skew_err, 0);

      // Full-width alignment and latency
      load_size(4);
      stream(3, 0, 0, -1, -1, fv);
      chk("first_row_latency", fv, N - 1);
      chk("t1_count", bus.fifo_count_out, 3);
      pop_row("t1_r0", 0, 1, 2, 3, 4'b1111);
      pop_row("t1_r1", 10, 11, 12, 13, 4'b1111);
      pop_row("t1_r2", 20, 21, 22, 23, 4'b1111);
      chk("t1_skew", bus.skew_err, 0);
      chk("t1_ovf", bus.overflow_err, 0);

      // Two active columns
      load_size(2);
      stream(3, 0, 0, -1, -1, fv);
      chk("t2_skew", bus.skew_err, 0);
      pop_row("t2_r0", 0, 1, 0, 0, 4'b0011);
      pop_row("t2_r1", 10, 11, 0, 0, 4'b0011);
      pop_row("t2_r2", 20, 21, 0, 0, 4'b0011);

      // Overflow with no consumer
      load_size(4);
      stream(5, 0, 0, -1, -1, fv);
      chk("t3_count", bus.fifo_count_out, 4);
      chk("t3_ovf", bus.overflow_err, 1);
      pop_row("t3_r0", 0, 1, 2, 3, 4'b1111);
      pop_row("t3_r1", 10, 11, 12, 13, 4'b1111);
      pop_row("t3_r2", 20, 21, 22, 23, 4'b1111);
      pop_row("t3_r3", 30, 31, 32, 33, 4'b1111);
      chk("t3_ovf_held", bus.overflow_err, 1);
      pulse_clear();
      chk("t3_ovf_cleared", bus.overflow_err, 0);

      // Push and pop on the same edge while full
      stream(4, 0, 0, -1, -1, fv);
      chk("t4_full", bus.fifo_count_out, 4);
      stream(1, 100, 0, N - 1, -1, fv);
      chk("t4_count", bus.fifo_count_out, 4);
      chk("t4_ovf", bus.overflow_err, 0);
      pop_row("t4_r0", 10, 11, 12, 13, 4'b1111);
      pop_row("t4_r1", 20, 21, 22, 23, 4'b1111);
      pop_row("t4_r2", 30, 31, 32, 33, 4'b1111);
      pop_row("t4_r3", 100, 101, 102, 103, 4'b1111);
      chk("t4_empty", bus.row_valid_out, 0);

      // Ready while empty is ignored
      bus.row_ready_in = 1'b1;
      repeat (2) step();
      bus.row_ready_in = 1'b0;
      chk("empty_ready_count", bus.fifo_count_out, 0);

      // Column 2 one cycle late
      stream(1, 0, 1, -1, -1, fv);
      chk("t5_skew", bus.skew_err, 1);
      chk("t5_count", bus.fifo_count_out, 1);
      pop_row("t5_r0", 0, 1, 0, 3, 4'b1111);
      pulse_clear();
      chk("t5_skew_cleared", bus.skew_err, 0);

      // Reset mid-stream with two rows buffered
      stream(2, 0, 0, -1, -1, fv);
      chk("t6_count", bus.fifo_count_out, 2);
      stream(3, 50, 0, -1, 2, fv);
      chk("t6_count_after", bus.fifo_count_out, 1);
      pop_row("t6_r0", 0, 0, 0, 0, 4'b0000);
      stream(1, 0, 0, -1, -1, fv);
      pop_row("t6_r1", 0, 0, 0, 0, 4'b0000);
      load_size(3);
      stream(1, 200, 0, -1, -1, fv);
      pop_row("t6_r2", 200, 201, 202, 0, 4'b0111);
      load_size(16);
      stream(1, 300, 0, -1, -1, fv);
      pop_row("t6_r3", 300, 301, 302, 303, 4'b1111);
      chk("final_skew", bus.skew_err, 0);
      chk("final_ovf", bus.overflow_err, 0);

      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
